// File: rtl/fadd_norm_pkg.sv
// fadd_norm_pkg: shared FPU constants, count-width helper and normalized-result field layout
package fadd_norm_pkg;
    localparam int EXP_W_DEF  = 8;
    localparam int MANT_W_DEF = 24;
    localparam int EXP_BIAS   = (1 << (EXP_W_DEF - 1)) - 1;
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
    typedef struct packed {
        logic                  sign;
        logic                  zero;
        logic                  subn;
        logic                  corr;
        logic [EXP_W_DEF-1:0]  exp;
        logic [MANT_W_DEF-1:0] mant;
    } norm_res_t;
endpackage

// File: rtl/fadd_norm_lzc.sv
// fadd_norm_lzc: combinational leading-zero counter with all-zero flag
module fadd_norm_lzc
    import fadd_norm_pkg::*;
#(
    parameter int WIDTH = MANT_W_DEF
) (
    input  logic [WIDTH-1:0]        vec_i,
    output logic [cnt_w(WIDTH)-1:0] cnt_o,
    output logic                    zero_o
);
    logic found;
    // scan from the MSB and count zeros until the first set bit
    always_comb begin
        cnt_o = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (vec_i[i]) found = 1'b1;
                else cnt_o = cnt_o + 1'b1;
            end
        end
    end
    assign zero_o = ~|vec_i;
endmodule

// File: rtl/fadd_norm.sv
// fadd_norm: two-stage FP-add normalization (LZA shift, one-bit fixup, subnormal clamp); optional FADD_NORM_CORR_CNT_EN adds a correction counter
module fadd_norm
    import fadd_norm_pkg::*;
#(
    parameter int WIDTH = MANT_W_DEF,
    parameter int EXP_W = EXP_W_DEF
`ifdef FADD_NORM_CORR_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef FADD_NORM_CORR_CNT_EN
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_lza,
    input  logic [EXP_W-1:0] in_exp,
    input  logic             in_sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mant,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sign,
    output logic             out_zero,
    output logic             out_subn,
    output logic             out_corr
);
    localparam int CW = cnt_w(WIDTH);
    logic [CW-1:0]    lz_cnt, lz;
    logic             lz_zero, big;
    logic [31:0]      sh;
    logic             s1_valid_q, out_valid_q, s1_load, s2_load;
    logic [WIDTH-1:0] m1_d, m1_q, mant_d, mant_q;
    logic [EXP_W-1:0] e1_d, e1_q, exp_d, exp_q;
    logic             clamp_d, clamp_q, sign_q, zero_q, msb;
    logic             subn_d, subn_q, corr_d, corr_q, osign_q, ozero_q;

    fadd_norm_lzc #(.WIDTH(WIDTH)) u_lzc (.vec_i(in_lza), .cnt_o(lz_cnt), .zero_o(lz_zero));

    assign s2_load   = !out_valid_q || out_ready;
    assign s1_load   = !s1_valid_q || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = out_valid_q;
    assign out_mant  = mant_q;
    assign out_exp   = exp_q;
    assign out_sign  = osign_q;
    assign out_zero  = ozero_q;
    assign out_subn  = subn_q;
    assign out_corr  = corr_q;

    // stage 1: shift by the LZA count unless that would push the exponent to/below zero
    always_comb begin
        lz      = lz_zero ? CW'(WIDTH - 1) : lz_cnt;
        big     = 32'(in_exp) > 32'(lz);
        sh      = big ? 32'(lz) : (in_exp == '0 ? 32'd0 : 32'(in_exp) - 32'd1);
        m1_d    = in_sum << sh;
        e1_d    = big ? in_exp - EXP_W'(lz) : '0;
        clamp_d = !big;
    end

    // stage 2: fix a one-bit LZA under-prediction, falling to subnormal when e1 is 1
    always_comb begin
        msb    = m1_q[WIDTH-1];
        mant_d = zero_q ? '0 : (!clamp_q && !msb && e1_q > 1) ? m1_q << 1 : m1_q;
        exp_d  = (zero_q || clamp_q) ? '0 : !msb ? (e1_q > 1 ? e1_q - 1'b1 : '0) : e1_q;
        subn_d = !zero_q && (clamp_q || (!msb && e1_q == 1));
        corr_d = !zero_q && !clamp_q && !msb;
    end

    // stage-1 register: advances when empty or when stage 2 drains it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            m1_q       <= '0;
            e1_q       <= '0;
            clamp_q    <= 1'b0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                m1_q    <= m1_d;
                e1_q    <= e1_d;
                clamp_q <= clamp_d;
                sign_q  <= in_sign;
                zero_q  <= in_sum == '0;
            end
        end
    end

    // stage-2 output register: held while the downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            mant_q      <= '0;
            exp_q       <= '0;
            osign_q     <= 1'b0;
            ozero_q     <= 1'b0;
            subn_q      <= 1'b0;
            corr_q      <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                mant_q  <= mant_d;
                exp_q   <= exp_d;
                osign_q <= sign_q;
                ozero_q <= zero_q;
                subn_q  <= subn_d;
                corr_q  <= corr_d;
            end
        end
    end

`ifdef FADD_NORM_CORR_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    assign corr_cnt = cnt_q;
    // saturating count of delivered beats that needed the one-bit correction
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) cnt_q <= '0;
        else if (out_valid_q && out_ready && corr_q && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fadd_norm.sv
// tb_fadd_norm: scoreboard bench for fadd_norm with directed vectors, back-pressure and mid-flight reset
module tb_fadd_norm;
    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic        zero;
        logic        subn;
        logic        corr;
    } res_t;

    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_ready, in_sign = 0;
    logic [23:0] in_sum = 0, in_lza = 0;
    logic [7:0]  in_exp = 0;
    logic        out_valid, out_ready = 1;
    logic [23:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_sign, out_zero, out_subn, out_corr;
`ifdef FADD_NORM_CORR_CNT_EN
    logic        cnt_clr = 0;
    logic [15:0] corr_cnt;
    int          exp_cnt = 0;
`endif

    int   errors = 0, checks = 0, acc = 0;
    res_t sb[$];
    res_t held;
    logic stall_prev = 0;

    fadd_norm dut (
        .clk(clk), .rst_n(rst_n),
`ifdef FADD_NORM_CORR_CNT_EN
        .cnt_clr(cnt_clr), .corr_cnt(corr_cnt),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_lza(in_lza),
        .in_exp(in_exp), .in_sign(in_sign), .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_sign(out_sign), .out_zero(out_zero),
        .out_subn(out_subn), .out_corr(out_corr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // offer one beat starting at posedge+1; push expectation once accepted
    task automatic send(input logic [23:0] s, input logic [23:0] l, input logic [7:0] e,
                        input logic sg, input res_t r);
        int n = 0;
        in_valid = 1; in_sum = s; in_lza = l; in_exp = e; in_sign = sg;
        @(negedge clk);
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
        end else begin
            sb.push_back(r);
            acc++;
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    function automatic res_t mk(input logic [23:0] m, input logic [7:0] e, input logic sg,
                                input logic z, input logic sb_, input logic c);
        return {m, e, sg, z, sb_, c};
    endfunction

    // monitor: pop and compare on each output transfer; check hold during stalls
    always @(negedge clk) begin
        res_t act, req;
        act = {out_mant, out_exp, out_sign, out_zero, out_subn, out_corr};
        if (!rst_n) stall_prev = 0;
        else if (out_valid && out_ready) begin
            stall_prev = 0;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: got %0h expected none", act);
            end else begin
                req = sb.pop_front();
                chk("beat", 64'(act), 64'(req));
`ifdef FADD_NORM_CORR_CNT_EN
                if (req.corr) exp_cnt++;
`endif
            end
        end else if (out_valid) begin
            if (stall_prev) chk("hold", 64'(act), 64'(held));
            held = act;
            stall_prev = 1;
        end else stall_prev = 0;
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_mant", 64'(out_mant), 64'd0);
        chk("rst_out_exp", 64'(out_exp), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        send(24'h008000, 24'h008000, 8'd100, 0, mk(24'h800000, 8'd92, 0, 0, 0, 0));
        send(24'h008000, 24'h010000, 8'd100, 1, mk(24'h800000, 8'd92, 1, 0, 0, 1));
        send(24'h000100, 24'h000100, 8'd5,   0, mk(24'h001000, 8'd0,  0, 0, 1, 0));
        send(24'h000000, 24'h000000, 8'd77,  1, mk(24'h000000, 8'd0,  1, 1, 0, 0));
        send(24'h400000, 24'h800000, 8'd1,   0, mk(24'h400000, 8'd0,  0, 0, 1, 1));
        send(24'h000010, 24'h000010, 8'd0,   0, mk(24'h000010, 8'd0,  0, 0, 1, 0));
        send(24'h800001, 24'h800000, 8'd200, 1, mk(24'h800001, 8'd200, 1, 0, 0, 0));
        send(24'h000800, 24'h000800, 8'd12,  0, mk(24'h400000, 8'd0,  0, 0, 1, 0));
        send(24'h000800, 24'h000800, 8'd13,  0, mk(24'h800000, 8'd1,  0, 0, 0, 0));
        send(24'h000001, 24'h000000, 8'd100, 0, mk(24'h800000, 8'd77, 0, 0, 0, 0));
        drain();
        out_ready = 0; acc = 0;
        fork
            begin
                send(24'h008000, 24'h008000, 8'd100, 0, mk(24'h800000, 8'd92, 0, 0, 0, 0));
                send(24'h008000, 24'h010000, 8'd100, 1, mk(24'h800000, 8'd92, 1, 0, 0, 1));
                send(24'h800001, 24'h800000, 8'd200, 1, mk(24'h800001, 8'd200, 1, 0, 0, 0));
                send(24'h000800, 24'h000800, 8'd13,  0, mk(24'h800000, 8'd1,  0, 0, 0, 0));
            end
            begin
                repeat (5) @(negedge clk);
                chk("bp_accepted", 64'(acc), 64'd2);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                @(posedge clk); #1 out_ready = 1;
            end
        join
        drain();
        chk("bp_total", 64'(acc), 64'd4);
        out_ready = 0;
        send(24'h008000, 24'h010000, 8'd100, 0, mk(24'h800000, 8'd92, 0, 0, 0, 1));
        send(24'h000100, 24'h000100, 8'd5,   1, mk(24'h001000, 8'd0,  1, 0, 1, 0));
        rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
`ifdef FADD_NORM_CORR_CNT_EN
        chk("midrst_corr_cnt", 64'(corr_cnt), 64'd0);
        exp_cnt = 0;
`endif
        @(posedge clk); #1 out_ready = 1;
        repeat (3) @(negedge clk);
        chk("midrst_no_output", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        send(24'h008000, 24'h010000, 8'd100, 1, mk(24'h800000, 8'd92, 1, 0, 0, 1));
        send(24'h400000, 24'h800000, 8'd1,   0, mk(24'h400000, 8'd0,  0, 0, 1, 1));
        drain();
`ifdef FADD_NORM_CORR_CNT_EN
        @(negedge clk);
        chk("corr_cnt", 64'(corr_cnt), 64'(exp_cnt));
        @(posedge clk); #1 cnt_clr = 1;
        @(posedge clk); #1 cnt_clr = 0;
        @(negedge clk);
        chk("corr_cnt_clr", 64'(corr_cnt), 64'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fadd_norm.md
Name: fadd_norm

Overview:
- Post-addition normalization stage of the FP adder. It sits directly downstream of the leading-zero anticipator and the mantissa adder.
- Consumes the raw sum mantissa plus the LZA indicator vector. Counts leading zeros of the indicator and left-shifts the sum.
- Fixes the LZA's possible one-bit under-prediction and adjusts the biased exponent, including the subnormal clamp.
- Two-stage pipeline with valid/ready handshake; feeds the rounding stage.

Parameters:
- WIDTH, 24, mantissa/sum width incl. hidden bit; also the LZA vector width.
- EXP_W, 8, biased exponent width.
- CNT_W, 16, width of the correction counter (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept input
- in_sum  in  WIDTH  unnormalized sum magnitude
- in_lza  in  WIDTH  LZA indicator; leading one = predicted MSB position, may be 1 too high
- in_exp  in  EXP_W  biased exponent before normalization
- in_sign  in  1  result sign
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_mant  out  WIDTH  normalized mantissa
- out_exp  out  EXP_W  adjusted biased exponent
- out_sign  out  1  passthrough sign
- out_zero  out  1  sum was exactly zero
- out_subn  out  1  result clamped to subnormal (out_exp=0)
- out_corr  out  1  stage-2 one-bit correction applied

Behaviour:
- Reset: on the clock edge with rst_n=0, both stage valid bits clear. out_valid=0 and all output data registers become 0. in_ready=1 the following cycle.
- Reset mid-operation: in-flight beats are discarded; no partial output.
- Handshake rules:
  - A transfer occurs on valid&ready.
  - Stage 2 loads when empty or out_ready=1.
  - Stage 1 loads when empty or stage 2 loads.
  - in_ready = !s1_valid | s2_load.
  - Full throughput of 1 beat/cycle with out_ready=1; latency 2 cycles from input transfer to out_valid.
  - Output data is held stable while out_valid & !out_ready.
  - Beat order is preserved.
- Stage 1:
  - lz = leading-zero count of in_lza. An all-zero vector gives lz=WIDTH-1.
  - If in_exp > lz: sh=lz, e1=in_exp-lz, clamp=0.
  - Else: sh = (in_exp==0) ? 0 : in_exp-1, e1=0, clamp=1.
  - Register m1 = in_sum << sh (WIDTH bits), e1, clamp, sign, zero = (in_sum==0).
- Stage 2:
  - zero=1: out_mant=0, out_exp=0, out_corr=0, out_subn=0.
  - Else if clamp=1: mant=m1, exp=0, subn=1, corr=0.
  - Else if m1[WIDTH-1]=0 and e1>1: mant=m1<<1, exp=e1-1, corr=1.
  - Else if m1[WIDTH-1]=0 and e1==1: mant=m1, exp=0, subn=1, corr=1.
  - Else: mant=m1, exp=e1.
- Exponent arithmetic is unsigned and never wraps below 0 (guaranteed by the clamp).
- Simultaneous events: input accept and output drain in the same cycle are legal. A full pipeline with out_ready=1 accepts a new beat.

Optional Feature:
- Macro: FADD_NORM_CORR_CNT_EN.
- When defined:
  - Adds port corr_cnt (out, CNT_W) and input cnt_clr (in, 1).
  - The counter increments on each output transfer with out_corr=1 and saturates at all-ones.
  - cnt_clr=1 forces 0, taking priority over increment.
  - Reset value is 0.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared FPU package/header holds:
  - EXP_W default, exponent bias constant;
  - clog2-based count-width function;
  - the normalized-result field layout shared with the rounding stage.
- One sub-module, lzc: parameterized combinational leading-zero counter on in_lza. It returns a count of clog2(WIDTH)+1 bits and an all_zero flag.

Test Plan (WIDTH=24, EXP_W=8, all output values appear 2 cycles after input transfer):
- Exact prediction: in_sum=24'h008000, in_lza=24'h008000, in_exp=100 -> out_mant=24'h800000, out_exp=92, out_corr=0.
- Under-prediction: in_sum=24'h008000, in_lza=24'h010000, in_exp=100 -> out_mant=24'h800000, out_exp=92, out_corr=1.
- Subnormal clamp: in_sum=24'h000100, in_lza=24'h000100, in_exp=5 -> out_mant=24'h001000, out_exp=0, out_subn=1.
- Zero: in_sum=0, in_lza=0, in_exp=77 -> out_zero=1, out_mant=0, out_exp=0.
- Back-pressure: 4 beats offered back-to-back with out_ready=0 -> 2 beats accepted, then in_ready=0. Releasing out_ready drains all 4 in order with no loss or duplication.
- Reset mid-flight: rst_n=0 for one cycle with both stages valid -> out_valid=0 next cycle; corr_cnt=0 when FADD_NORM_CORR_CNT_EN is defined.
